// File: rtl/radar_servo_pkg.sv
// Shared types and sizing helpers for the radar servo PWM generator.
package radar_servo_pkg;

  localparam int unsigned ANGLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Counter width able to hold 0..frame_clks-1.
  function automatic int unsigned cnt_width(input int unsigned frame_clks);
    return (frame_clks > 1) ? $clog2(frame_clks) : 1;
  endfunction

endpackage

// File: rtl/radar_servo_slew.sv
// Next-frame angle selection: slew-limited toward the command when
// SERVO_SLEW_EN is defined, otherwise a direct pass-through.
module radar_servo_slew
  import radar_servo_pkg::*;
#(
  parameter int unsigned MAX_STEP = 4
) (
  input  logic [ANGLE_W-1:0] i_cur_angle,
  input  logic [ANGLE_W-1:0] i_angle_in,
  output logic [ANGLE_W-1:0] o_next_angle
);

`ifdef SERVO_SLEW_EN
  localparam int unsigned STEP_LIM = (MAX_STEP > 255) ? 255 : MAX_STEP;
  localparam logic signed [ANGLE_W:0]   STEP_S      = (ANGLE_W+1)'(STEP_LIM);
  localparam logic signed [ANGLE_W+1:0] ANGLE_MAX_S = (ANGLE_W+2)'((1 << ANGLE_W) - 1);

  logic signed [ANGLE_W:0]   w_diff;
  logic signed [ANGLE_W:0]   w_step;
  logic signed [ANGLE_W+1:0] w_sum;

  // Clamp the signed error to +/-STEP, then saturate the result into range.
  always_comb begin
    w_diff = $signed({1'b0, i_angle_in}) - $signed({1'b0, i_cur_angle});
    if (w_diff > STEP_S) begin
      w_step = STEP_S;
    end else if (w_diff < -STEP_S) begin
      w_step = -STEP_S;
    end else begin
      w_step = w_diff;
    end
    w_sum = $signed({2'b00, i_cur_angle}) + $signed({w_step[ANGLE_W], w_step});
    if (w_sum[ANGLE_W+1]) begin
      o_next_angle = '0;
    end else if (w_sum > ANGLE_MAX_S) begin
      o_next_angle = '1;
    end else begin
      o_next_angle = w_sum[ANGLE_W-1:0];
    end
  end
`else
  logic w_unused_cfg;

  assign o_next_angle = i_angle_in;
  assign w_unused_cfg = ^{i_cur_angle, MAX_STEP};
`endif

endmodule

// File: rtl/radar_servo_pwm.sv
// Hobby-servo PWM generator for the radar sweep; angle is latched only at
// frame boundaries. Optional slew limiting via SERVO_SLEW_EN.
module radar_servo_pwm
  import radar_servo_pkg::*;
#(
  parameter int unsigned FRAME_CLKS = 1_000_000,
  parameter int unsigned MIN_CLKS   = 50_000,
  parameter int unsigned STEP_CLKS  = 195,
  parameter int unsigned MAX_STEP   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [ANGLE_W-1:0] i_angle_in,
  output logic               o_pwm_out,
  output logic               o_frame_tick,
  output logic [ANGLE_W-1:0] o_cur_angle,
  output logic               o_settled
);

  localparam int unsigned      CNT_W      = cnt_width(FRAME_CLKS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   r_pulse_clks;
  logic [CNT_W-1:0]   w_pulse_next;
  logic [ANGLE_W-1:0] r_angle;
  logic [ANGLE_W-1:0] w_next_angle;
  logic               w_load;
  logic               w_frame_start;

  radar_servo_slew #(
    .MAX_STEP (MAX_STEP)
  ) u_slew (
    .i_cur_angle  (r_angle),
    .i_angle_in   (i_angle_in),
    .o_next_angle (w_next_angle)
  );

  // State and frame counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state; w_load marks the edge that enters a new frame.
  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (i_enable) begin
          w_state_next = ST_HIGH;
          w_load       = 1'b1;
        end
      end
      ST_HIGH: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc == r_pulse_clks) begin
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_cnt == FRAME_LAST) begin
          w_cnt_next = '0;
          if (i_enable) begin
            w_state_next = ST_HIGH;
            w_load       = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pulse width precomputed one cycle ahead so the multiply stays off the compare.
  always_comb begin
    w_pulse_next = CNT_W'(MIN_CLKS) + CNT_W'(w_next_angle) * CNT_W'(STEP_CLKS);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_angle      <= '0;
      r_pulse_clks <= CNT_W'(MIN_CLKS);
    end else if (w_load) begin
      r_angle      <= w_next_angle;
      r_pulse_clks <= w_pulse_next;
    end
  end

  assign w_frame_start = (r_state == ST_HIGH) && (r_cnt == '0);

  // Registered outputs: pin, frame tick, applied angle and settled flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pwm_out    <= 1'b0;
      o_frame_tick <= 1'b0;
      o_cur_angle  <= '0;
      o_settled    <= 1'b0;
    end else begin
      o_pwm_out    <= (r_state == ST_HIGH);
      o_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        o_cur_angle <= r_angle;
      end
      o_settled <= (o_cur_angle == i_angle_in);
    end
  end

endmodule

// File: tb/tb_radar_servo_pwm.sv
// Self-checking bench for radar_servo_pwm: vector table plus frame scoreboard.
module tb_radar_servo_pwm;

  localparam int FRAME = 1000;

  typedef struct {
    logic [7:0] angle;
    logic [7:0] exp_cur;
    int         exp_high;
  } vec_t;

  typedef struct {
    logic [7:0] cur;
    int         high;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] angle_in;
  logic       pwm_out;
  logic       frame_tick;
  logic [7:0] cur_angle;
  logic       settled;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   skip_period = 1'b1;

  always #5 clk = ~clk;

  radar_servo_pwm #(
    .FRAME_CLKS (1000),
    .MIN_CLKS   (100),
    .STEP_CLKS  (2),
    .MAX_STEP   (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_angle_in   (angle_in),
    .o_pwm_out    (pwm_out),
    .o_frame_tick (frame_tick),
    .o_cur_angle  (cur_angle),
    .o_settled    (settled)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_tick && n < 3 * FRAME);
    if (!frame_tick) check("tick_timeout", 0, 1);
  endtask

  // Frame monitor: period, applied angle and high time against the scoreboard.
  int   cyc = 0;
  int   last_tick = 0;
  bit   tick_valid = 1'b0;
  bit   in_frame = 1'b0;
  bit   pwm_prev = 1'b0;
  int   hi_cnt = 0;
  exp_t cur_exp;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame   = 1'b0;
      tick_valid = 1'b0;
      pwm_prev   = 1'b0;
      hi_cnt     = 0;
    end else begin
      if (frame_tick) begin
        if (tick_valid && !skip_period) check("frame_period", cyc - last_tick, FRAME);
        skip_period = 1'b0;
        tick_valid  = 1'b1;
        last_tick   = cyc;
        hi_cnt      = 0;
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
          in_frame = 1'b0;
        end else begin
          cur_exp  = sb.pop_front();
          in_frame = 1'b1;
          check("cur_angle", int'(cur_angle), int'(cur_exp.cur));
        end
      end
      if (pwm_out) hi_cnt++;
      if (pwm_prev && !pwm_out && in_frame) begin
        check("high_time", hi_cnt, cur_exp.high);
        in_frame = 1'b0;
      end
      pwm_prev = pwm_out;
    end
  end

  initial begin
    vec_t vecs[4];
    int   n_hi;
    int   n_tk;
    vecs[0] = '{8'd0,   8'd0,   100};
    vecs[1] = '{8'd255, 8'd255, 610};
    vecs[2] = '{8'd128, 8'd128, 356};
    vecs[3] = '{8'd10,  8'd10,  120};

    reset    = 1'b1;
    enable   = 1'b0;
    angle_in = 8'd0;
    wait_cycles(3);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_cur", int'(cur_angle), 0);
    check("rst_settled", int'(settled), 0);
    reset = 1'b0;
    wait_cycles(1);
    check("settled_idle", int'(settled), 1);
    wait_cycles(20);
    check("idle_pwm", int'(pwm_out), 0);

`ifndef SERVO_SLEW_EN
    // Enable latency: sampled at edge N, pulse and tick at N+1.
    sb.push_back('{vecs[0].exp_cur, vecs[0].exp_high});
    skip_period = 1'b1;
    enable      = 1'b1;
    wait_cycles(1);
    check("lat_pwm_n", int'(pwm_out), 0);
    wait_cycles(1);
    check("lat_pwm_n1", int'(pwm_out), 1);
    check("lat_tick_n1", int'(frame_tick), 1);

    for (int i = 1; i < 4; i++) begin
      angle_in = vecs[i].angle;
      sb.push_back('{vecs[i].exp_cur, vecs[i].exp_high});
      wait_tick();
    end

    // Mid-frame angle change only lands at the next boundary.
    wait_cycles(49);
    angle_in = 8'd200;
    sb.push_back('{8'd200, 500});
    wait_cycles(2);
    check("settled_drop", int'(settled), 0);
    check("cur_hold", int'(cur_angle), 10);
    wait_tick();

    // Enable drop inside a 356-clk pulse: full pulse, then park low.
    angle_in = 8'd128;
    sb.push_back('{8'd128, 356});
    wait_tick();
    wait_cycles(29);
    enable = 1'b0;
    wait_cycles(FRAME);
    n_hi = 0;
    n_tk = 0;
    for (int k = 0; k < 600; k++) begin
      wait_cycles(1);
      if (pwm_out) n_hi++;
      if (frame_tick) n_tk++;
    end
    check("park_pwm_high", n_hi, 0);
    check("park_ticks", n_tk, 0);
    check("sb_drain_a", sb.size(), 0);

    // Reset in the middle of a pulse, then a clean restart.
    angle_in = 8'd255;
    sb.push_back('{8'd255, 610});
    skip_period = 1'b1;
    enable      = 1'b1;
    wait_tick();
    wait_cycles(199);
    reset = 1'b1;
    sb.delete();
    wait_cycles(1);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_cur", int'(cur_angle), 0);
    check("midrst_tick", int'(frame_tick), 0);
    angle_in = 8'd128;
    sb.push_back('{8'd128, 356});
    sb.push_back('{8'd128, 356});
    skip_period = 1'b1;
    reset       = 1'b0;
    wait_tick();
    check("restart_cur", int'(cur_angle), 128);
    wait_tick();
    enable = 1'b0;
    wait_cycles(FRAME + 100);
    check("sb_drain_b", sb.size(), 0);
`else
    // Slew-limited approach from 0 to 10 at 4 codes per frame.
    sb.push_back('{8'd0, 100});
    skip_period = 1'b1;
    enable      = 1'b1;
    wait_tick();
    angle_in = 8'd10;
    sb.push_back('{8'd4, 108});
    sb.push_back('{8'd8, 116});
    sb.push_back('{8'd10, 120});
    wait_tick();
    check("slew_cur_4", int'(cur_angle), 4);
    check("slew_settled_4", int'(settled), 0);
    wait_tick();
    check("slew_cur_8", int'(cur_angle), 8);
    check("slew_settled_8", int'(settled), 0);
    wait_tick();
    check("slew_cur_10", int'(cur_angle), 10);
    wait_cycles(1);
    check("slew_settled_10", int'(settled), 1);
    sb.push_back('{8'd10, 120});
    wait_tick();
    enable = 1'b0;
    wait_cycles(FRAME + 100);
    check("sb_drain_slew", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
